// File: rtl/muldiv_ctrl.sv
// MUL/DIV execute sequencer. It drives an external Booth multiplier and has its own restoring divider.
// Optional build macro MULDIV_ABORT_EN adds an abort input that cancels an operation in flight.
module muldiv_ctrl #(
    parameter int unsigned MUL_CYCLES = 2
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] mul_m,
    output logic [31:0] mul_q,
    input  logic [63:0] mul_p,
`ifdef MULDIV_ABORT_EN
    input  logic        abort,
`endif
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DONE     = 2'd3
    } state_t;

    state_t      state_reg, state_next;
    logic [3:0]  cnt_reg;
    logic [5:0]  bit_cnt_reg;
    logic [31:0] rem_reg, quo_reg, dvsr_reg;
    logic        sign_q_reg, sign_r_reg;

    logic        abort_hit;
    logic        accept, accept_mul, accept_div, div_zero;
    logic        mul_capture, div_step, div_finish;
    logic [31:0] a_mag, b_mag;
    logic [32:0] shifted, diff;

`ifdef MULDIV_ABORT_EN
    assign abort_hit = abort;
`else
    assign abort_hit = 1'b0;
`endif

    assign accept     = start && !op[1] && (state_reg == IDLE || state_reg == DONE);
    assign accept_mul = accept && !op[0];
    assign accept_div = accept &&  op[0];
    assign div_zero   = (b == 32'd0);

    assign a_mag = a[31] ? (~a + 32'd1) : a;
    assign b_mag = b[31] ? (~b + 32'd1) : b;

    // 33-bit trial subtract; bit 32 set means the partial remainder is below the divisor
    assign shifted = {rem_reg, quo_reg[31]};
    assign diff    = shifted - {1'b0, dvsr_reg};

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        mul_capture = 1'b0;
        div_step    = 1'b0;
        div_finish  = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                state_next = IDLE;
                if (accept_mul) begin
                    state_next = MUL_WAIT;
                end else if (accept_div) begin
                    state_next = div_zero ? DONE : DIV_RUN;
                end
            end
            MUL_WAIT: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd0) begin
                    mul_capture = 1'b1;
                    state_next  = DONE;
                end
            end
            DIV_RUN: begin
                if (abort_hit) begin
                    state_next = IDLE;
                end else if (bit_cnt_reg == 6'd0) begin
                    div_finish = 1'b1;
                    state_next = DONE;
                end else begin
                    div_step = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            mul_m       <= 32'd0;
            mul_q       <= 32'd0;
            hi          <= 32'd0;
            lo          <= 32'd0;
            div_by_zero <= 1'b0;
            cnt_reg     <= 4'd0;
            bit_cnt_reg <= 6'd0;
            rem_reg     <= 32'd0;
            quo_reg     <= 32'd0;
            dvsr_reg    <= 32'd0;
            sign_q_reg  <= 1'b0;
            sign_r_reg  <= 1'b0;
        end else begin
            if (accept_mul) begin
                mul_m   <= a;
                mul_q   <= b;
                cnt_reg <= 4'(MUL_CYCLES - 1);
            end else if (state_reg == MUL_WAIT && !abort_hit && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end

            if (accept_div && div_zero) begin
                lo          <= 32'hFFFF_FFFF;
                hi          <= a;
                div_by_zero <= 1'b1;
            end else if (accept_div) begin
                rem_reg     <= 32'd0;
                quo_reg     <= a_mag;
                dvsr_reg    <= b_mag;
                sign_q_reg  <= a[31] ^ b[31];
                sign_r_reg  <= a[31];
                bit_cnt_reg <= 6'd32;
            end

            if (div_step) begin
                rem_reg     <= diff[32] ? shifted[31:0] : diff[31:0];
                quo_reg     <= {quo_reg[30:0], ~diff[32]};
                bit_cnt_reg <= bit_cnt_reg - 6'd1;
            end

            if (mul_capture) begin
                hi          <= mul_p[63:32];
                lo          <= mul_p[31:0];
                div_by_zero <= 1'b0;
            end else if (div_finish) begin
                lo          <= sign_q_reg ? (~quo_reg + 32'd1) : quo_reg;
                hi          <= sign_r_reg ? (~rem_reg + 32'd1) : rem_reg;
                div_by_zero <= 1'b0;
            end
        end
    end

    assign busy = (state_reg == MUL_WAIT) || (state_reg == DIV_RUN);
    assign done = (state_reg == DONE);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: results are predicted at issue time and compared on done.
// Also covers the illegal-op drop, back-to-back issue, asynchronous clear and (when built with it) abort.
module tb_muldiv_ctrl;

    localparam int MUL_CYCLES = 2;

    logic        clk = 1'b0;
    logic        clear = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic [31:0] mul_m, mul_q;
    logic [63:0] mul_p;
    logic        busy, done, div_by_zero;
    logic [31:0] hi, lo;
`ifdef MULDIV_ABORT_EN
    logic        abort = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    // behavioural stand-in for the external Booth multiplier
    assign mul_p = $signed({{32{mul_m[31]}}, mul_m}) * $signed({{32{mul_q[31]}}, mul_q});

    muldiv_ctrl #(.MUL_CYCLES(MUL_CYCLES)) dut (
        .clock       (clk),
        .clear       (clear),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .mul_m       (mul_m),
        .mul_q       (mul_q),
        .mul_p       (mul_p),
`ifdef MULDIV_ABORT_EN
        .abort       (abort),
`endif
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb);
        exp_t   e;
        longint sa, sbv, q, r, p;
        sa  = longint'($signed(aa));
        sbv = longint'($signed(bb));
        if (o == 2'b00) begin
            p     = sa * sbv;
            e.hi  = p[63:32];
            e.lo  = p[31:0];
            e.dbz = 1'b0;
            e.lat = MUL_CYCLES;
        end else if (bb == 32'd0) begin
            e.hi  = aa;
            e.lo  = 32'hFFFF_FFFF;
            e.dbz = 1'b1;
            e.lat = 0;
        end else begin
            q     = sa / sbv;
            r     = sa % sbv;
            e.hi  = r[31:0];
            e.lo  = q[31:0];
            e.dbz = 1'b0;
            e.lat = 33;
        end
        return e;
    endfunction

    // Call at a negedge; returns at the negedge after the sampling edge (edge 0).
    task automatic issue(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb, input bit track);
        start = 1'b1;
        op    = o;
        a     = aa;
        b     = bb;
        if (track) sb.push_back(model(o, aa, bb));
        @(negedge clk);
        start = 1'b0;
        op    = 2'b00;
    endtask

    task automatic wait_done(input string tag, input int repulse_at);
        int   k;
        exp_t e;
        k = 0;
        while (!done && k < 100) begin
            if (k == 0) check({tag, "_busy"}, busy, 1);
            if (k == repulse_at) begin
                start = 1'b1;
                op    = 2'b01;
                a     = 32'd5;
                b     = 32'd1;
            end
            @(negedge clk);
            start = 1'b0;
            k++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({tag, "_lat"}, k, e.lat);
            check({tag, "_hi"}, hi, e.hi);
            check({tag, "_lo"}, lo, e.lo);
            check({tag, "_dbz"}, div_by_zero, e.dbz);
            $display("%s: done after %0d cycles hi=%08h lo=%08h dbz=%0b", tag, k, hi, lo, div_by_zero);
        end
    endtask

    task automatic watch_quiet(input string tag, input int cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (busy || done) seen = 1'b1;
        end
        check({tag, "_quiet"}, seen, 0);
    endtask

    initial begin
        logic [31:0] hold_hi, hold_lo;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        #1 clear = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dbz", div_by_zero, 0);
        check("rst_mul_m", mul_m, 0);
        check("rst_mul_q", mul_q, 0);
        clear = 1'b0;
        @(negedge clk);

        // 7 * -3
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 1);
        wait_done("mul_7x-3", -1);
        check("mul_m_hold", mul_m, 32'd7);
        check("mul_q_hold", mul_q, 32'hFFFF_FFFD);
        check("mul_7x-3_lo_const", lo, 32'hFFFF_FFEB);
        @(negedge clk);

        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1);
        wait_done("mul_min_sq", -1);
        check("mul_min_sq_hi_const", hi, 32'h4000_0000);
        @(negedge clk);
        issue(2'b10, 32'd1, 32'd2, 0);
        watch_quiet("illegal_op", 5);

        // -7 / 2 with a stray start mid-operation
        issue(2'b01, 32'hFFFF_FFF9, 32'd2, 1);
        wait_done("div_-7/2", 10);
        check("div_-7/2_lo_const", lo, 32'hFFFF_FFFD);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);

        issue(2'b01, 32'd100, 32'd0, 1);
        wait_done("div_by0", -1);
        @(negedge clk);
        issue(2'b00, 32'd3, 32'd4, 1);
        wait_done("mul_3x4", -1);
        @(negedge clk);

        // overflow case, then back-to-back MUL issued during its DONE cycle
        issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        wait_done("div_ovf", -1);
        issue(2'b00, 32'd2, 32'd2, 1);
        wait_done("mul_b2b", -1);
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 1));
            ra  = $urandom;
            rb  = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
            issue(rop, ra, rb, 1);
            wait_done($sformatf("rand%0d", i), -1);
            @(negedge clk);
        end

        // asynchronous clear partway through a division
        issue(2'b01, 32'd1000, 32'd7, 0);
        repeat (9) @(negedge clk);
        #2 clear = 1'b1;
        #1;
        check("clr_busy", busy, 0);
        check("clr_hi", hi, 0);
        check("clr_lo", lo, 0);
        check("clr_dbz", div_by_zero, 0);
        check("clr_mul_m", mul_m, 0);
        @(negedge clk);
        clear = 1'b0;
        watch_quiet("after_clear", 40);

`ifdef MULDIV_ABORT_EN
        issue(2'b00, 32'd5, 32'd6, 1);
        wait_done("mul_5x6", -1);
        hold_hi = hi;
        hold_lo = lo;
        @(negedge clk);
        issue(2'b01, 32'd1000, 32'd7, 0);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, hold_hi);
        check("abort_lo", lo, hold_lo);
        watch_quiet("after_abort", 40);
`else
        hold_hi = 32'd0;
        hold_lo = 32'd0;
`endif

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
Multi-cycle sequencer for the CPU's MUL/DIV execute path, sitting between the decode/control unit and the combinational Booth multiplier.
- MUL: registers operands, drives the external Booth multiplier, waits a fixed multicycle window, then captures the 64-bit product into HI/LO.
- DIV: performs signed division internally, one quotient bit per cycle.
- Provides a start/busy/done handshake to the control unit.

Parameters:
MUL_CYCLES, 2, cycles allowed for the combinational multiplier path before capture; legal range 1..15.

Ports:
clock  in  1  system clock, rising edge
clear  in  1  asynchronous active-high reset
start  in  1  request; sampled only when accepting (IDLE or DONE)
op  in  2  00 = signed MUL, 01 = signed DIV, 1x = illegal (request ignored)
a  in  32  multiplicand / dividend
b  in  32  multiplier / divisor
mul_m  out  32  multiplicand to the Booth multiplier (registered)
mul_q  out  32  multiplier to the Booth multiplier (registered)
mul_p  in  64  signed product from the Booth multiplier
busy  out  1  high in MUL_WAIT and DIV_RUN
done  out  1  one-cycle pulse; HI/LO valid while high
hi  out  32  MUL: P[63:32]; DIV: remainder
lo  out  32  MUL: P[31:0]; DIV: quotient
div_by_zero  out  1  set on a DIV completion with b == 0

Behaviour:
- Reset (clear high, asynchronous): state = IDLE. The following are all 0: mul_m, mul_q, hi, lo, busy, done, div_by_zero, counters.
- States: IDLE, MUL_WAIT, DIV_RUN, DONE.
- Accepting states: IDLE and DONE. A request needs start = 1 and op in {00, 01}.
  - Any other start (while busy, or op = 1x) is dropped silently; no state change.
  - start sampled in DONE gives back-to-back operation with no idle gap.
- Edge numbering: edge 0 is the rising edge that samples an accepted start.
- MUL:
  - Edge 0: mul_m <= a, mul_q <= b, cnt <= MUL_CYCLES-1, go to MUL_WAIT.
  - Each MUL_WAIT edge: if cnt == 0, then hi/lo <= mul_p, div_by_zero <= 0, go to DONE; otherwise cnt--.
  - Capture happens at edge MUL_CYCLES; done is high in the cycle after it.
  - mul_m/mul_q hold their values until the next accepted MUL.
- DIV (signed, truncating toward zero; remainder takes the dividend's sign):
  - Edge 0, b == 0: lo <= 32'hFFFFFFFF, hi <= a, div_by_zero <= 1, go to DONE. done is high in the cycle after edge 0.
  - Edge 0, b != 0: latch |a|, |b|, sign_q = a[31]^b[31], sign_r = a[31]; go to DIV_RUN with bit count 32.
  - Edges 1..32: restoring division, one bit per edge. Shift {rem, quo} left, trial-subtract |b| using a 33-bit subtract, restore if negative.
  - Edge 33: apply two's-complement sign fix-up, write lo = quotient, hi = remainder, div_by_zero <= 0, go to DONE.
  - done is high in the cycle after edge 33, i.e. 34 cycles after edge 0.
  - Magnitudes are 32-bit unsigned: |0x80000000| = 0x80000000.
  - 0x80000000 / -1 yields lo = 0x80000000, hi = 0 (wraps, no flag).
- DONE lasts exactly one cycle, then IDLE, unless a new request is accepted.
- hi, lo and div_by_zero hold between completions; they change only at capture.
- busy is low in IDLE and DONE.

Optional Feature:
MULDIV_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort high at an edge in MUL_WAIT or DIV_RUN: go to IDLE. No done pulse; hi, lo and div_by_zero are unchanged.
  - abort has priority over completion on the same edge.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; operations always run to completion.

Test Plan:
1. MUL a = 7, b = -3 (0xFFFFFFFD), MUL_CYCLES = 2 -> busy high for 2 cycles; done one cycle after edge 2; hi = FFFFFFFF, lo = FFFFFFEB.
2. MUL a = b = 0x80000000 -> hi = 40000000, lo = 00000000, div_by_zero = 0. Then start with op = 10 in IDLE -> no busy, no done.
3. DIV a = -7 (FFFFFFF9), b = 2 -> done exactly in cycle 34 after edge 0; lo = FFFFFFFD, hi = FFFFFFFF. Re-pulse start mid-operation -> ignored; result unchanged.
4. DIV a = 100, b = 0 -> done in the next cycle; div_by_zero = 1; lo = FFFFFFFF, hi = 00000064. A following MUL 3×4 clears the flag: lo = 0000000C, hi = 0.
5. DIV a = 0x80000000, b = FFFFFFFF -> lo = 80000000, hi = 0. Then start asserted during its DONE cycle (MUL 2×2) -> accepted with no idle gap; lo = 4.
6. clear pulsed at edge 10 of a DIV -> busy and all outputs 0 immediately (asynchronous), no done afterwards. With MULDIV_ABORT_EN: abort at edge 5 of a DIV -> IDLE, hi/lo keep their prior values, no done.
